// File: rtl/serdes_rx_pkg.sv
// Shared types for the SERDES receive framer: FSM states, frame header layout, default sync word.
package serdes_rx_pkg;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hA5C3;

  typedef enum logic [1:0] {
    HUNT,
    HEADER,
    PAYLOAD,
    CHECK
  } state_t;

  typedef struct packed {
    logic [3:0] ftype;
    logic [3:0] rsvd;
    logic [7:0] len;
  } header_t;

  // A header is usable only if it announces between 1 and max_len payload words.
  function automatic logic header_len_ok(header_t h, int unsigned max_len);
    return (h.len != 8'd0) && (32'(h.len) <= max_len);
  endfunction

endpackage

// File: rtl/serdes_rx_framer_if.sv
// Word input, payload stream and frame status bundle of the framer.
// SERDES_RX_FRAMER_STATS_EN adds the good/bad frame counters.
interface serdes_rx_framer_if #(
  parameter int WORD_WIDTH = 16
);
  logic [WORD_WIDTH-1:0] word_in;
  logic                  word_vld;
  logic [WORD_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_vld;
  logic                  out_rdy;
  logic                  frame_done;
  logic                  frame_err;
  logic [3:0]            frame_type;
`ifdef SERDES_RX_FRAMER_STATS_EN
  logic [15:0]           stat_ok;
  logic [15:0]           stat_err;
`endif

  modport master (
    output word_in, word_vld, out_rdy,
`ifdef SERDES_RX_FRAMER_STATS_EN
    input  stat_ok, stat_err,
`endif
    input  out_data, out_last, out_vld, frame_done, frame_err, frame_type
  );

  modport slave (
    input  word_in, word_vld, out_rdy,
`ifdef SERDES_RX_FRAMER_STATS_EN
    output stat_ok, stat_err,
`endif
    output out_data, out_last, out_vld, frame_done, frame_err, frame_type
  );
endinterface

// File: rtl/serdes_rx_fifo.sv
// Synchronous payload FIFO; full/empty from an extra pointer wrap bit, head word read combinationally.
module serdes_rx_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Stale storage is hidden so the stream reads zero whenever nothing is queued.
  assign rdata = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/serdes_rx_framer.sv
// Sync hunt, header parse, payload buffering and XOR checksum check for deserialized words.
// SERDES_RX_FRAMER_STATS_EN adds saturating good/bad frame counters.
module serdes_rx_framer
  import serdes_rx_pkg::*;
#(
  parameter int                    WORD_WIDTH = 16,
  parameter logic [WORD_WIDTH-1:0] SYNC_WORD  = WORD_WIDTH'(SYNC_WORD_DEF),
  parameter int                    MAX_LEN    = 15,
  parameter int                    FIFO_DEPTH = 16,
  parameter int                    TIMEOUT    = 64
) (
  input logic               clk,
  input logic               rst,
  serdes_rx_framer_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                state_reg, state_next;
  logic [7:0]            cnt_reg, cnt_next;
  logic [WORD_WIDTH-1:0] csum_reg, csum_next;
  logic                  ovf_reg, ovf_next;
  logic [TW-1:0]         timer_reg, timer_next;
  logic [3:0]            ftype_reg, ftype_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;
  logic [3:0]            frame_type_reg, frame_type_next;
  header_t               hdr;
  logic                  len_ok;
  logic                  timeout;
  logic                  push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [WORD_WIDTH:0]   fifo_rdata;
`ifdef SERDES_RX_FRAMER_STATS_EN
  logic [15:0]           stat_ok_reg;
  logic [15:0]           stat_err_reg;
`endif

  assign hdr     = header_t'(bus.word_in[15:0]);
  assign len_ok  = header_len_ok(hdr, MAX_LEN);
  assign timeout = (state_reg != HUNT) && !bus.word_vld && (timer_reg == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= HUNT;
      cnt_reg        <= '0;
      csum_reg       <= '0;
      ovf_reg        <= 1'b0;
      timer_reg      <= '0;
      ftype_reg      <= '0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      frame_type_reg <= '0;
`ifdef SERDES_RX_FRAMER_STATS_EN
      stat_ok_reg    <= '0;
      stat_err_reg   <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      csum_reg       <= csum_next;
      ovf_reg        <= ovf_next;
      timer_reg      <= timer_next;
      ftype_reg      <= ftype_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
      frame_type_reg <= frame_type_next;
`ifdef SERDES_RX_FRAMER_STATS_EN
      if (done_next && !err_next && (stat_ok_reg != 16'hFFFF))  stat_ok_reg  <= stat_ok_reg + 1'b1;
      if (done_next && err_next && (stat_err_reg != 16'hFFFF))  stat_err_reg <= stat_err_reg + 1'b1;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    if (timeout) begin
      state_next = HUNT;
    end else if (bus.word_vld) begin
      case (state_reg)
        HUNT:    if (bus.word_in == SYNC_WORD) state_next = HEADER;
        HEADER:  state_next = len_ok ? PAYLOAD : HUNT;
        PAYLOAD: if (cnt_reg == 8'd1) state_next = CHECK;
        CHECK:   state_next = HUNT;
        default: state_next = HUNT;
      endcase
    end
  end

  always_comb begin
    push            = 1'b0;
    cnt_next        = cnt_reg;
    csum_next       = csum_reg;
    ovf_next        = ovf_reg;
    ftype_next      = ftype_reg;
    done_next       = 1'b0;
    err_next        = 1'b0;
    frame_type_next = frame_type_reg;
    timer_next      = (state_reg == HUNT || bus.word_vld || timeout) ? '0 : timer_reg + 1'b1;
    if (timeout) begin
      done_next       = 1'b1;
      err_next        = 1'b1;
      frame_type_next = ftype_reg;
    end else if (bus.word_vld) begin
      case (state_reg)
        HEADER: begin
          ftype_next = hdr.ftype;
          cnt_next   = hdr.len;
          csum_next  = '0;
          ovf_next   = 1'b0;
          if (!len_ok) begin
            done_next       = 1'b1;
            err_next        = 1'b1;
            frame_type_next = hdr.ftype;
          end
        end
        PAYLOAD: begin
          // A push into a full FIFO is dropped by the FIFO; remember it for this frame's status.
          push      = 1'b1;
          csum_next = csum_reg ^ bus.word_in;
          cnt_next  = cnt_reg - 8'd1;
          ovf_next  = ovf_reg | fifo_full;
        end
        CHECK: begin
          done_next       = 1'b1;
          err_next        = (bus.word_in != csum_reg) | ovf_reg;
          frame_type_next = ftype_reg;
        end
        default: ;
      endcase
    end
  end

  serdes_rx_fifo #(
    .WIDTH (WORD_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({cnt_reg == 8'd1, bus.word_in}),
    .pop   (bus.out_rdy),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_data   = fifo_rdata[WORD_WIDTH-1:0];
  assign bus.out_last   = fifo_rdata[WORD_WIDTH];
  assign bus.out_vld    = !fifo_empty;
  assign bus.frame_done = done_reg;
  assign bus.frame_err  = err_reg;
  assign bus.frame_type = frame_type_reg;
`ifdef SERDES_RX_FRAMER_STATS_EN
  assign bus.stat_ok    = stat_ok_reg;
  assign bus.stat_err   = stat_err_reg;
`endif

endmodule

// File: tb/tb_serdes_rx_framer.sv
// Self-checking bench for serdes_rx_framer: directed frames plus randomized frames against a frame-level model.
module tb_serdes_rx_framer;
  logic clk;
  logic rst;
  bit   rdy_rand;
  int   pass_cnt;
  int   check_cnt;

  logic [16:0] exp_words[$];
  logic [16:0] got_q[$];
  logic [4:0]  exp_done[$];
  logic [4:0]  done_q[$];

  serdes_rx_framer_if #(.WORD_WIDTH(16)) bus ();

  serdes_rx_framer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: record accepted payload words and frame closures.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_vld && bus.out_rdy) got_q.push_back({bus.out_last, bus.out_data});
      if (bus.frame_done) done_q.push_back({bus.frame_err, bus.frame_type});
    end
  end

  always @(posedge clk) begin
    if (rdy_rand) begin
      #1;
      bus.out_rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    idle(gap);
    bus.word_in  = w;
    bus.word_vld = 1'b1;
    @(posedge clk);
    #1;
    bus.word_vld = 1'b0;
  endtask

  task automatic clear_q();
    exp_words.delete();
    got_q.delete();
    exp_done.delete();
    done_q.delete();
  endtask

  // Sends one frame and appends what the specification says must come out of it.
  task automatic send_frame(input logic [3:0] typ, input int len, input bit bad_csum, input int gap_max);
    logic [15:0] w;
    logic [15:0] csum;
    csum = '0;
    send_word(16'hA5C3, $urandom_range(0, gap_max));
    send_word({typ, 4'h0, 8'(len)}, $urandom_range(0, gap_max));
    if (len < 1 || len > 15) begin
      exp_done.push_back({1'b1, typ});
      return;
    end
    for (int i = 0; i < len; i++) begin
      w = ($urandom_range(0, 9) == 0) ? 16'hA5C3 : 16'($urandom);
      csum ^= w;
      exp_words.push_back({(i == len - 1), w});
      send_word(w, $urandom_range(0, gap_max));
    end
    if (bad_csum) csum ^= 16'($urandom_range(1, 65535));
    send_word(csum, $urandom_range(0, gap_max));
    exp_done.push_back({bad_csum, typ});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    check_cnt++; if (bus.out_vld !== 1'b0) $display("FAIL reset_out_vld got %b exp 0", bus.out_vld); else pass_cnt++;
    check_cnt++; if (bus.out_data !== 16'h0) $display("FAIL reset_out_data got %h exp 0000", bus.out_data); else pass_cnt++;
    check_cnt++; if (bus.out_last !== 1'b0) $display("FAIL reset_out_last got %b exp 0", bus.out_last); else pass_cnt++;
    check_cnt++; if (bus.frame_done !== 1'b0) $display("FAIL reset_frame_done got %b exp 0", bus.frame_done); else pass_cnt++;
    check_cnt++; if (bus.frame_err !== 1'b0) $display("FAIL reset_frame_err got %b exp 0", bus.frame_err); else pass_cnt++;
    check_cnt++; if (bus.frame_type !== 4'h0) $display("FAIL reset_frame_type got %h exp 0", bus.frame_type); else pass_cnt++;
    rst = 1'b0;
    idle(2);
    $display("reset: outputs idle after reset");
  endtask

  task automatic test_good_frame();
    clear_q();
    bus.out_rdy = 1'b1;
    send_word(16'h1234, 0);
    send_word(16'hA5C3, 0); send_word(16'h1003, 0);
    send_word(16'h0001, 0); send_word(16'h0002, 0); send_word(16'h0004, 0);
    send_word(16'h0007, 0);
    exp_words = '{17'h00001, 17'h00002, 17'h10004};
    exp_done  = '{5'h01};
    idle(6);
    check_cnt++; if (got_q.size() !== exp_words.size()) $display("FAIL good_count got %0d exp %0d", got_q.size(), exp_words.size()); else pass_cnt++;
    foreach (exp_words[i]) if (i < got_q.size()) begin check_cnt++; if (got_q[i] !== exp_words[i]) $display("FAIL good_word[%0d] got %h exp %h", i, got_q[i], exp_words[i]); else pass_cnt++; end
    check_cnt++; if (done_q.size() !== 1) $display("FAIL good_done_count got %0d exp 1", done_q.size()); else pass_cnt++;
    if (done_q.size() > 0) begin check_cnt++; if (done_q[0] !== exp_done[0]) $display("FAIL good_status got %h exp %h", done_q[0], exp_done[0]); else pass_cnt++; end
    $display("good_frame: %0d words, %0d closures", got_q.size(), done_q.size());
  endtask

  task automatic test_bad_checksum();
    clear_q();
    send_word(16'hA5C3, 0); send_word(16'h1003, 0);
    send_word(16'h0001, 0); send_word(16'h0002, 0); send_word(16'h0004, 0);
    send_word(16'h0006, 0);
    exp_words = '{17'h00001, 17'h00002, 17'h10004};
    exp_done  = '{5'h11};
    idle(6);
    check_cnt++; if (got_q.size() !== exp_words.size()) $display("FAIL badcs_count got %0d exp %0d", got_q.size(), exp_words.size()); else pass_cnt++;
    foreach (exp_words[i]) if (i < got_q.size()) begin check_cnt++; if (got_q[i] !== exp_words[i]) $display("FAIL badcs_word[%0d] got %h exp %h", i, got_q[i], exp_words[i]); else pass_cnt++; end
    check_cnt++; if (done_q.size() !== 1) $display("FAIL badcs_done_count got %0d exp 1", done_q.size()); else pass_cnt++;
    if (done_q.size() > 0) begin check_cnt++; if (done_q[0] !== exp_done[0]) $display("FAIL badcs_status got %h exp %h", done_q[0], exp_done[0]); else pass_cnt++; end
    $display("bad_checksum: %0d words, %0d closures", got_q.size(), done_q.size());
  endtask

  task automatic test_bad_length();
    clear_q();
    send_frame(4'h0, 0, 1'b0, 0);
    send_frame(4'h0, 16, 1'b0, 0);
    send_frame(4'h7, 2, 1'b0, 0);
    idle(6);
    check_cnt++; if (got_q.size() !== exp_words.size()) $display("FAIL badlen_count got %0d exp %0d", got_q.size(), exp_words.size()); else pass_cnt++;
    foreach (exp_words[i]) if (i < got_q.size()) begin check_cnt++; if (got_q[i] !== exp_words[i]) $display("FAIL badlen_word[%0d] got %h exp %h", i, got_q[i], exp_words[i]); else pass_cnt++; end
    check_cnt++; if (done_q.size() !== exp_done.size()) $display("FAIL badlen_done_count got %0d exp %0d", done_q.size(), exp_done.size()); else pass_cnt++;
    foreach (exp_done[i]) if (i < done_q.size()) begin check_cnt++; if (done_q[i] !== exp_done[i]) $display("FAIL badlen_status[%0d] got %h exp %h", i, done_q[i], exp_done[i]); else pass_cnt++; end
    $display("bad_length: %0d words, %0d closures", got_q.size(), done_q.size());
  endtask

  task automatic test_overflow();
    clear_q();
    bus.out_rdy = 1'b0;
    send_frame(4'h5, 15, 1'b0, 0);
    send_frame(4'h6, 15, 1'b0, 0);
    idle(4);
    check_cnt++; if (bus.out_vld !== 1'b1) $display("FAIL ovf_held_vld got %b exp 1", bus.out_vld); else pass_cnt++;
    // Nothing is popped, so only the first FIFO_DEPTH payload words survive.
    while (exp_words.size() > 16) void'(exp_words.pop_back());
    exp_done[1][4] = 1'b1;
    bus.out_rdy = 1'b1;
    idle(24);
    check_cnt++; if (got_q.size() !== exp_words.size()) $display("FAIL ovf_count got %0d exp %0d", got_q.size(), exp_words.size()); else pass_cnt++;
    foreach (exp_words[i]) if (i < got_q.size()) begin check_cnt++; if (got_q[i] !== exp_words[i]) $display("FAIL ovf_word[%0d] got %h exp %h", i, got_q[i], exp_words[i]); else pass_cnt++; end
    check_cnt++; if (done_q.size() !== exp_done.size()) $display("FAIL ovf_done_count got %0d exp %0d", done_q.size(), exp_done.size()); else pass_cnt++;
    foreach (exp_done[i]) if (i < done_q.size()) begin check_cnt++; if (done_q[i] !== exp_done[i]) $display("FAIL ovf_status[%0d] got %h exp %h", i, done_q[i], exp_done[i]); else pass_cnt++; end
    $display("overflow: %0d words delivered, %0d closures", got_q.size(), done_q.size());
  endtask

  task automatic test_timeout();
    int  n;
    bit  seen;
    clear_q();
    bus.out_rdy = 1'b1;
    send_word(16'hA5C3, 0); send_word(16'h2005, 0); send_word(16'h0001, 0);
    send_word(16'h0002, 63);
    n = 0;
    seen = 1'b0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (bus.frame_done) begin
        seen = 1'b1;
        n = k;
      end
    end
    check_cnt++; if (!seen) $display("FAIL timeout_seen got none within 100 cycles exp frame_done"); else pass_cnt++;
    check_cnt++; if (n !== 64) $display("FAIL timeout_latency got %0d exp 64", n); else pass_cnt++;
    idle(4);
    exp_words = '{17'h00001, 17'h00002};
    exp_done  = '{5'h12};
    check_cnt++; if (got_q.size() !== exp_words.size()) $display("FAIL timeout_count got %0d exp %0d", got_q.size(), exp_words.size()); else pass_cnt++;
    foreach (exp_words[i]) if (i < got_q.size()) begin check_cnt++; if (got_q[i] !== exp_words[i]) $display("FAIL timeout_word[%0d] got %h exp %h", i, got_q[i], exp_words[i]); else pass_cnt++; end
    check_cnt++; if (done_q.size() !== 1) $display("FAIL timeout_done_count got %0d exp 1", done_q.size()); else pass_cnt++;
    if (done_q.size() > 0) begin check_cnt++; if (done_q[0] !== exp_done[0]) $display("FAIL timeout_status got %h exp %h", done_q[0], exp_done[0]); else pass_cnt++; end
    $display("timeout: closed after %0d idle cycles", n);
  endtask

  task automatic test_reset_mid_frame();
    clear_q();
    bus.out_rdy = 1'b0;
    send_word(16'hA5C3, 0); send_word(16'h1005, 0);
    send_word(16'h0011, 0); send_word(16'h0022, 0); send_word(16'h0033, 0);
    check_cnt++; if (bus.out_vld !== 1'b1) $display("FAIL rstmid_pre_vld got %b exp 1", bus.out_vld); else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    check_cnt++; if (bus.out_vld !== 1'b0) $display("FAIL rstmid_out_vld got %b exp 0", bus.out_vld); else pass_cnt++;
    check_cnt++; if (bus.out_data !== 16'h0) $display("FAIL rstmid_out_data got %h exp 0000", bus.out_data); else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_q();
    bus.out_rdy = 1'b1;
    send_frame(4'h9, 4, 1'b0, 1);
    idle(6);
    check_cnt++; if (got_q.size() !== exp_words.size()) $display("FAIL rstmid_count got %0d exp %0d", got_q.size(), exp_words.size()); else pass_cnt++;
    foreach (exp_words[i]) if (i < got_q.size()) begin check_cnt++; if (got_q[i] !== exp_words[i]) $display("FAIL rstmid_word[%0d] got %h exp %h", i, got_q[i], exp_words[i]); else pass_cnt++; end
    check_cnt++; if (done_q.size() !== 1) $display("FAIL rstmid_done_count got %0d exp 1", done_q.size()); else pass_cnt++;
    if (done_q.size() > 0) begin check_cnt++; if (done_q[0] !== exp_done[0]) $display("FAIL rstmid_status got %h exp %h", done_q[0], exp_done[0]); else pass_cnt++; end
    $display("reset_mid_frame: %0d words after reset, %0d closures", got_q.size(), done_q.size());
  endtask

  task automatic test_random();
    logic [15:0] w;
    int          len;
    clear_q();
    rdy_rand = 1'b1;
    for (int f = 0; f < 25; f++) begin
      for (int j = 0, nz = $urandom_range(0, 2); j < nz; j++) begin
        w = 16'($urandom);
        if (w == 16'hA5C3) w = 16'h0000;
        send_word(w, $urandom_range(0, 3));
      end
      if ($urandom_range(0, 7) == 0) len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(16, 255));
      else len = int'($urandom_range(1, 15));
      send_frame(4'($urandom), len, ($urandom_range(0, 3) == 0), 3);
      idle(80);
    end
    rdy_rand = 1'b0;
    #2;
    bus.out_rdy = 1'b1;
    idle(20);
    check_cnt++; if (got_q.size() !== exp_words.size()) $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_words.size()); else pass_cnt++;
    foreach (exp_words[i]) if (i < got_q.size()) begin check_cnt++; if (got_q[i] !== exp_words[i]) $display("FAIL rand_word[%0d] got %h exp %h", i, got_q[i], exp_words[i]); else pass_cnt++; end
    check_cnt++; if (done_q.size() !== exp_done.size()) $display("FAIL rand_done_count got %0d exp %0d", done_q.size(), exp_done.size()); else pass_cnt++;
    foreach (exp_done[i]) if (i < done_q.size()) begin check_cnt++; if (done_q[i] !== exp_done[i]) $display("FAIL rand_status[%0d] got %h exp %h", i, done_q[i], exp_done[i]); else pass_cnt++; end
    $display("random: %0d words, %0d closures", got_q.size(), done_q.size());
  endtask

  initial begin
    pass_cnt     = 0;
    check_cnt    = 0;
    rdy_rand     = 1'b0;
    rst          = 1'b1;
    bus.word_in  = '0;
    bus.word_vld = 1'b0;
    bus.out_rdy  = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_length();
    test_overflow();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
